// File: rtl/muldiv_sequencer.sv
//==============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle MUL / UDIV unit for EX; one bit per cycle, stalls the pipe.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int          WIDTH       = 64,
  parameter logic [10:0] MUL_OPCODE  = 11'b10011011000,
  parameter logic [10:0] UDIV_OPCODE = 11'b10011010110
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [10:0]      opcode_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_MUL_RUN = 2'd1;
  localparam logic [1:0] c_DIV_RUN = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Shared register: product accumulator in MUL, partial remainder in UDIV.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic             w_is_mul, w_is_div, w_legal, w_last;
  logic [WIDTH-1:0] w_mul_add, w_acc_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub, w_quo;

  assign w_is_mul  = (opcode_i == MUL_OPCODE);
  assign w_is_div  = (opcode_i == UDIV_OPCODE);
  assign w_legal   = w_is_mul | w_is_div;
  assign w_last    = (count_q == CW'(WIDTH - 1));

  assign w_mul_add = b_q[0] ? a_q : '0;
  assign w_acc_sum = acc_q + w_mul_add;

  assign w_rem_sh  = {acc_q, a_q[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, b_q});
  // Only consumed when w_ge holds, so the difference always fits in WIDTH bits.
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - b_q;
  assign w_quo     = {a_q[WIDTH-2:0], w_ge};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (start_i) begin
          if (w_is_mul) begin
            a_d     = operand_a_i;
            b_d     = operand_b_i;
            acc_d   = '0;
            count_d = '0;
            state_d = c_MUL_RUN;
          end else if (w_is_div) begin
            if (operand_b_i != '0) begin
              a_d     = operand_a_i;
              b_d     = operand_b_i;
              acc_d   = '0;
              count_d = '0;
              state_d = c_DIV_RUN;
            end else begin
              result_d = '0;
              done_d   = 1'b1;
              state_d  = c_DONE;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      c_MUL_RUN: begin
        acc_d   = w_acc_sum;
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q + CW'(1);
        if (w_last) begin
          count_d  = '0;
          result_d = w_acc_sum;
          done_d   = 1'b1;
          state_d  = c_DONE;
        end
      end
      c_DIV_RUN: begin
        acc_d   = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
        a_d     = w_quo;
        count_d = count_q + CW'(1);
        if (w_last) begin
          count_d  = '0;
          result_d = w_quo;
          done_d   = 1'b1;
          state_d  = c_DONE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d   = c_IDLE;
      count_d   = '0;
      result_d  = result_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
    end

    busy_d = (state_d == c_MUL_RUN) || (state_d == c_DIV_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= c_IDLE;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Combinational so the issuing instruction is held in its own cycle.
  assign stall_o   = ((state_q == c_IDLE) && start_i && w_legal) || busy_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign illegal_o = illegal_q;
  assign result_o  = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
//==============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Directed self-checking bench for muldiv_sequencer with result scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam logic [10:0] c_MUL  = 11'b10011011000;
  localparam logic [10:0] c_UDIV = 11'b10011010110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] opcode = '0;
  logic [63:0] opa = '0;
  logic [63:0] opb = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done, illegal;
  logic [63:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];

  muldiv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .opcode_i    (opcode),
    .operand_a_i (opa),
    .operand_b_i (opb),
    .flush_i     (flush),
    .stall_o     (stall),
    .busy_o      (busy),
    .done_o      (done),
    .illegal_o   (illegal),
    .result_o    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else                chk("result", result, sb.pop_front());
    end
  end

  // Issues one operation in cycle 0 and follows it; optional mid-run start, flush or async reset.
  task automatic do_op(input string tag, input logic [10:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res,
                       input int exp_done, input int exp_busy,
                       input int mid_cyc, input int flush_cyc, input int rst_cyc);
    int done_cyc = -1;
    int busy_n   = 0;
    int stall_n  = 0;
    @(posedge clk); #1;
    start = 1'b1; opcode = op; opa = a; opb = b;
    if (exp_done >= 0) sb.push_back(exp_res);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy)  busy_n++;
      if (stall) stall_n++;
      if (done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0) break;
      @(posedge clk); #1;
      start = (c + 1 == mid_cyc);
      opa   = 64'd5; opb = 64'd5; opcode = c_MUL;
      flush = (c + 1 == flush_cyc);
      if (c + 1 == rst_cyc) begin
        reset = 1'b1;
        #1;
        chk({tag, "_rst_busy"},    {63'd0, busy},    64'd0);
        chk({tag, "_rst_done"},    {63'd0, done},    64'd0);
        chk({tag, "_rst_illegal"}, {63'd0, illegal}, 64'd0);
        chk({tag, "_rst_stall"},   {63'd0, stall},   64'd0);
        chk({tag, "_rst_result"},  result,           64'd0);
        #1 reset = 1'b0;
      end
    end
    start = 1'b0; flush = 1'b0;
    if (done_cyc < 0 && exp_done >= 0) void'(sb.pop_back());
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_busy + 1));
  endtask

  initial begin
    #3;
    chk("reset_busy",    {63'd0, busy},    64'd0);
    chk("reset_done",    {63'd0, done},    64'd0);
    chk("reset_illegal", {63'd0, illegal}, 64'd0);
    chk("reset_stall",   {63'd0, stall},   64'd0);
    chk("reset_result",  result,           64'd0);
    @(negedge clk); reset = 1'b0;

    do_op("mul_7x6",   c_MUL,  64'd7, 64'd6, 64'd42, 65, 64, -1, -1, -1);
    do_op("mul_wrap",  c_MUL,  64'h8000_0000_0000_0000, 64'd2, 64'd0, 65, 64, -1, -1, -1);
    do_op("mul_ff",    c_MUL,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 65, 64, -1, -1, -1);
    do_op("div_100_7", c_UDIV, 64'd100, 64'd7, 64'd14, 65, 64, -1, -1, -1);
    do_op("div_5_9",   c_UDIV, 64'd5, 64'd9, 64'd0, 65, 64, -1, -1, -1);
    do_op("div_max_1", c_UDIV, ~64'd0, 64'd1, ~64'd0, 65, 64, -1, -1, -1);

    // Unsupported opcode: one-cycle illegal pulse, no stall, result kept.
    @(posedge clk); #1;
    start = 1'b1; opcode = 11'h000; opa = 64'd1; opb = 64'd1;
    @(negedge clk);
    chk("illegal_stall_c0", {63'd0, stall}, 64'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("illegal_pulse", {63'd0, illegal}, 64'd1);
    chk("illegal_busy",  {63'd0, busy},    64'd0);
    @(negedge clk);
    chk("illegal_cleared", {63'd0, illegal}, 64'd0);
    chk("illegal_result",  result, ~64'd0);

    do_op("div_by_0",  c_UDIV, 64'd123, 64'd0, 64'd0, 1, 0, -1, -1, -1);
    do_op("mul_midst", c_MUL,  64'd11, 64'd13, 64'd143, 65, 64, 10, -1, -1);
    do_op("mul_flush", c_MUL,  64'd3, 64'd4, 64'd0, -1, 10, -1, 10, -1);
    chk("flush_result", result, 64'd143);

    // Flush and start together in IDLE: nothing is accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; opcode = c_MUL; opa = 64'd2; opb = 64'd2;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("flush_start_done", {63'd0, done}, 64'd0);

    do_op("div_reset", c_UDIV, 64'd1000, 64'd3, 64'd0, -1, 19, -1, -1, 20);
    do_op("mul_3x3",   c_MUL,  64'd3, 64'd3, 64'd9, 65, 64, -1, -1, -1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
